// File: rtl/mmio_tx_port_pkg.sv
// Shared register map for the MMIO transmit port: word offsets inside the
// 16-byte window and the bit layout of the STATUS register.
package mmio_tx_port_pkg;

    // Byte offsets of the registers inside the window
    localparam logic [3:0] OFS_TXDATA = 4'h0;
    localparam logic [3:0] OFS_STATUS = 4'h4;
    localparam logic [3:0] OFS_PASS   = 4'h8;
    localparam logic [3:0] OFS_RSVD   = 4'hC;

    // STATUS register bit positions
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_CNT_LSB = 2;
    localparam int STAT_CNT_W   = 6;
    localparam int STAT_OVF_LSB = 16;
    localparam int STAT_OVF_W   = 16;

    // Word index (Adr[3:2]) to byte offset; byte lanes are ignored
    function automatic logic [3:0] word_offset(input logic [1:0] widx);
        return {widx, 2'b00};
    endfunction

endpackage

// File: rtl/mmio_tx_port_tx_fifo.sv
// Small show-ahead FIFO: the head word is presented combinationally so a push
// is visible on the next cycle. Reads out as zero while empty.
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [31:0]                din,
    output logic [31:0]                dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees a slot on the same edge, so push is allowed when full if popping
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next-state for pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; stale words are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mmio_tx_port.sv
// Memory-mapped transmit port: register decode, overflow counter and the
// PASS/done latch around a tx_fifo that streams words to a consumer.
module mmio_tx_port
    import mmio_tx_port_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h0000_0100,
    parameter int          DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done,
    output logic [7:0]  done_code
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]    offset;
    logic          wr_en, push, overflow;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic [31:0]   status;
    logic [1:0]    unused_adr_bits;

    logic [15:0]   ovf_cnt_q, ovf_cnt_d;
    logic          done_q, done_d;
    logic [7:0]    done_code_q, done_code_d;

    assign unused_adr_bits = Adr[1:0];

    assign Hit    = (Adr[31:4] == BASE[31:4]);
    assign offset = word_offset(Adr[3:2]);
    assign wr_en  = MemWrite && Hit;
    assign push   = wr_en && (offset == OFS_TXDATA);

    // A word is lost only when the FIFO is full and nothing leaves on this edge
    assign overflow = push && fifo_full && !(tx_ready && !fifo_empty);

    tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (tx_ready),
        .din   (WriteData),
        .dout  (tx_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_valid  = !fifo_empty;
    assign done      = done_q;
    assign done_code = done_code_q;

    // Next-state for the overflow counter (saturating) and the PASS latch
    always_comb begin
        ovf_cnt_d   = ovf_cnt_q;
        done_d      = done_q;
        done_code_d = done_code_q;
        if (wr_en && offset == OFS_STATUS) begin
            ovf_cnt_d = '0;
        end else if (overflow && ovf_cnt_q != 16'hFFFF) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
        if (wr_en && offset == OFS_PASS) begin
            done_d      = 1'b1;
            done_code_d = WriteData[7:0];
        end
    end

    // Control registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_cnt_q   <= '0;
            done_q      <= 1'b0;
            done_code_q <= '0;
        end else begin
            ovf_cnt_q   <= ovf_cnt_d;
            done_q      <= done_d;
            done_code_q <= done_code_d;
        end
    end

    // Assemble STATUS and select read data; unmapped and write-only offsets read as zero
    always_comb begin
        status = '0;
        status[STAT_EMPTY]                 = fifo_empty;
        status[STAT_FULL]                  = fifo_full;
        status[STAT_CNT_LSB +: CW]         = fifo_count;
        status[STAT_OVF_LSB +: STAT_OVF_W] = ovf_cnt_q;

        ReadData = '0;
        if (Hit) begin
            case (offset)
                OFS_STATUS: ReadData = status;
                OFS_PASS:   ReadData = {23'b0, done_q, done_code_q};
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_tx_port.sv
// Scoreboard bench for mmio_tx_port: stores are mirrored into an expected-word
// queue and every cycle the FIFO head is compared against the queue front.
module tb_mmio_tx_port;

    localparam logic [31:0] BASE_T  = 32'h0000_0100;
    localparam int          DEPTH_T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        done;
    logic [7:0]  done_code;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [15:0] ovf_m;
    logic        done_m;
    logic [7:0]  code_m;

    mmio_tx_port #(.BASE(BASE_T), .DEPTH(DEPTH_T)) dut (
        .clk       (clk),
        .reset     (reset),
        .Adr       (Adr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (done),
        .done_code (done_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n;
        n = exp_q.size();
        return {ovf_m, 8'b0, 6'(n), (n == DEPTH_T), (n == 0)};
    endfunction

    // Combinational read of one register, no clock edge consumed
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Adr      = a;
        MemWrite = 1'b0;
        #1;
        chk(tag, ReadData, exp);
    endtask

    // One clock cycle: check outputs against the model, then apply the same edge to the model
    task automatic cycle(input logic st, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        logic exp_hit;
        Adr       = a;
        WriteData = d;
        MemWrite  = st;
        tx_ready  = rdy;
        #1;
        exp_hit = ((a >> 4) == (BASE_T >> 4));
        chk("hit", {31'b0, Hit}, {31'b0, exp_hit});
        chk("valid", {31'b0, tx_valid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) chk("data", tx_data, exp_q[0]);
        else                   chk("data_empty", tx_data, 32'h0);
        if (st) $display("store adr=%h data=%h ready=%0d", a, d, rdy);
        if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
        if (st && exp_hit) begin
            case (a[3:2])
                2'd0: begin
                    if (exp_q.size() < DEPTH_T) exp_q.push_back(d);
                    else if (ovf_m != 16'hFFFF) ovf_m++;
                end
                2'd1: ovf_m = '0;
                2'd2: begin done_m = 1'b1; code_m = d[7:0]; end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        tx_ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH_T && exp_q.size() != 0; i++) cycle(1'b0, BASE_T + 32'h4, 32'h0, 1'b1);
        cycle(1'b0, BASE_T + 32'h4, 32'h0, 1'b1);
    endtask

    initial begin
        reset = 1'b0; Adr = '0; WriteData = '0; MemWrite = 1'b0; tx_ready = 1'b0;
        ovf_m = '0; done_m = 1'b0; code_m = '0;
        #1;
        chk("rst_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_data", tx_data, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        rd_chk("rst_status", BASE_T + 32'h4, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Three words held back, then streamed out
        cycle(1'b1, BASE_T, 32'h11, 1'b0);
        cycle(1'b1, BASE_T, 32'h22, 1'b0);
        cycle(1'b1, BASE_T, 32'h33, 1'b0);
        rd_chk("status3", BASE_T + 32'h4, 32'h0000_000C);
        drain();

        // Overfill by two, clear the overflow count, then push+pop while full
        for (int i = 1; i <= 10; i++) cycle(1'b1, BASE_T, 32'hA00 + i, 1'b0);
        rd_chk("status_ovf", BASE_T + 32'h4, 32'h0002_0022);
        chk("status_ovf_model", exp_status(), 32'h0002_0022);
        cycle(1'b1, BASE_T + 32'h4, 32'hFFFF_FFFF, 1'b0);
        rd_chk("status_clr", BASE_T + 32'h4, 32'h0000_0022);
        cycle(1'b1, BASE_T, 32'hAB, 1'b1);
        rd_chk("status_full_pp", BASE_T + 32'h4, 32'h0000_0022);
        drain();

        // PASS register
        cycle(1'b1, BASE_T + 32'h8, 32'h7, 1'b0);
        chk("done", {31'b0, done}, {31'b0, done_m});
        chk("done_code", {24'b0, done_code}, {24'b0, code_m});
        rd_chk("pass_rd", BASE_T + 32'h8, 32'h107);
        cycle(1'b1, BASE_T + 32'h8, 32'h1_2309, 1'b0);
        chk("done2", {31'b0, done}, 32'h1);
        chk("done_code2", {24'b0, done_code}, 32'h09);

        // Outside the window and reserved/write-only offsets
        cycle(1'b1, BASE_T + 32'h10, 32'hDEAD, 1'b0);
        cycle(1'b1, BASE_T + 32'hC, 32'hBEEF, 1'b0);
        rd_chk("status_nochg", BASE_T + 32'h4, exp_status());
        rd_chk("miss_rd", BASE_T + 32'h14, 32'h0);
        chk("miss_hit", {31'b0, Hit}, 32'h0);
        rd_chk("rsvd_rd", BASE_T + 32'hC, 32'h0);
        rd_chk("txdata_rd", BASE_T, 32'h0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 60; i++) begin
            cycle($urandom_range(0, 3) != 0, BASE_T + {$urandom_range(0, 1) == 0 ? 2'd0 : 2'd3, 2'b00},
                  $urandom, $urandom_range(0, 2) == 0);
        end
        rd_chk("status_rand", BASE_T + 32'h4, exp_status());
        drain();

        // Asynchronous reset with words queued
        for (int i = 0; i < 5; i++) cycle(1'b1, BASE_T, 32'h500 + i, 1'b0);
        rd_chk("status5", BASE_T + 32'h4, 32'h0000_0014);
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete(); ovf_m = '0; done_m = 1'b0; code_m = '0;
        chk("arst_valid", {31'b0, tx_valid}, 32'h0);
        chk("arst_data", tx_data, 32'h0);
        chk("arst_done", {31'b0, done}, 32'h0);
        chk("arst_code", {24'b0, done_code}, 32'h0);
        rd_chk("arst_status", BASE_T + 32'h4, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle(1'b1, BASE_T, 32'h55, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_tx_port.md
MMIO_TX_PORT -- requirements
Module: mmio_tx_port

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_0100: byte base address of the 16-byte register window.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO entries, power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Adr  input  32  processor byte address.
REQ-006 SHALL have port WriteData  input  32  processor store data.
REQ-007 SHALL have port MemWrite  input  1  processor store strobe, sampled at rising clk.
REQ-008 SHALL have port ReadData  output  32  register read data, combinational from Adr.
REQ-009 SHALL have port Hit  output  1  Adr lies inside the window; top uses it to select ReadData over memory.
REQ-010 SHALL have port tx_data  output  32  head-of-FIFO word.
REQ-011 SHALL have port tx_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port tx_ready  input  1  consumer accepts the word on this edge when tx_valid=1.
REQ-013 SHALL have port done  output  1  program wrote the PASS register.
REQ-014 SHALL have port done_code  output  8  code written with PASS.

Function
REQ-015 Hit SHALL be 1 iff Adr[31:4]==BASE[31:4]; Adr[1:0] ignored.
REQ-016 Offset 0x0 TXDATA: a store with Hit SHALL push WriteData; reads SHALL return 0.
REQ-017 Offset 0x4 STATUS read SHALL be {ovf_cnt[15:0], 8'b0, count[5:2 padded], full, empty}: bit0 empty, bit1 full, bits[7:2] count, bits[31:16] overflow count.
REQ-018 Offset 0x4 store SHALL clear the overflow count; FIFO contents SHALL be unaffected.
REQ-019 Offset 0x8 PASS store SHALL set done=1 and done_code=WriteData[7:0] on that edge; done SHALL stay set until reset; later PASS stores SHALL update done_code only. Reads SHALL return {23'b0, done, done_code}.
REQ-020 Offset 0xC SHALL be reserved: reads return 0, stores ignored.
REQ-021 ReadData SHALL be 0 when Hit=0.
REQ-022 A push SHALL be visible on tx_valid/tx_data one cycle later (after the same edge).
REQ-023 A pop SHALL occur on an edge where tx_valid=1 and tx_ready=1; tx_ready with tx_valid=0 SHALL have no effect.
REQ-024 tx_valid SHALL never depend combinationally on tx_ready; tx_data SHALL be 0 when empty.
REQ-025 Push and pop on the same edge SHALL both occur, count unchanged, including when full.
REQ-026 Push when full without pop SHALL drop the word and increment the overflow count, saturating at 16'hFFFF.
REQ-027 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH; full iff count==DEPTH.
REQ-028 Order SHALL be strict FIFO; no word duplicated or reordered.

Reset
REQ-029 reset low SHALL immediately clear pointers, count, overflow count, done, done_code; tx_valid=0, tx_data=0.
REQ-030 Reset mid-transfer SHALL discard all queued words; storage array need not be cleared.
REQ-031 First push SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-032 Shared package SHALL hold offset constants (TXDATA 0x0, STATUS 0x4, PASS 0x8) and STATUS bit positions.
REQ-033 FIFO SHALL be sub-module tx_fifo (push, pop, data, count, full, empty, parameter DEPTH); mmio_tx_port holds decode, overflow counter, PASS logic.

Verification
REQ-034 Store 32'h11,22,33 to BASE, tx_ready=0 -> STATUS reads count=3, empty=0; then tx_ready=1 -> tx_data 11,22,33 on consecutive cycles, then tx_valid=0.
REQ-035 Store 10 words with tx_ready=0, DEPTH=8 -> full=1, ovf_cnt=2, words 9-10 lost; store to BASE+4 -> ovf_cnt=0, count still 8.
REQ-036 Full FIFO, tx_ready=1, simultaneous store of 32'hAB -> count stays 8, 32'hAB emerges last.
REQ-037 Store 7 to BASE+8 -> done=1, done_code=7 next cycle; read BASE+8 returns 32'h107.
REQ-038 Store to BASE+0x10 and read BASE+0xC -> Hit=0 / ReadData=0, no FIFO change.
REQ-039 Assert reset with 5 words queued -> tx_valid=0, count=0 immediately, without a clock edge.
